// File: rtl/xpmwrap_sdpram_stream.sv
// Simple dual-port RAM with byte-enable writes and a backpressured read stream.
// Reads are tracked through the RAM latency and land in a credit-protected FIFO.
module xpmwrap_sdpram_stream #(
   parameter int ADDR_WIDTH     = 6,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_WIDTH     = 8,
   parameter int READ_LATENCY   = 2,
   parameter int RSP_FIFO_DEPTH = 4
) (
   input  logic                                    clk,
   input  logic                                    rstn,
   input  logic                                    wr_en,
   input  logic [ADDR_WIDTH-1:0]                   wr_addr,
   input  logic [DATA_WIDTH-1:0]                   wr_data,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]        wr_be,
   input  logic                                    rd_req_valid,
   output logic                                    rd_req_ready,
   input  logic [ADDR_WIDTH-1:0]                   rd_req_addr,
   output logic                                    rd_rsp_valid,
   input  logic                                    rd_rsp_ready,
   output logic [DATA_WIDTH-1:0]                   rd_rsp_data,
   output logic [$clog2(RSP_FIFO_DEPTH+1)-1:0]     rd_outstanding
);

   localparam int NB = DATA_WIDTH / BYTE_WIDTH;
   localparam int OW = $clog2(RSP_FIFO_DEPTH + 1);
   localparam int PW = $clog2(RSP_FIFO_DEPTH);
   localparam logic [OW-1:0] DEPTH_C = OW'(RSP_FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_P  = PW'(RSP_FIFO_DEPTH - 1);

   if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_lat
      $error("READ_LATENCY must be 1..8");
   end
   if (RSP_FIFO_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
      $error("RSP_FIFO_DEPTH must be >= READ_LATENCY+1");
   end
   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   logic                    collide;
   logic                    accept;
   logic                    push;
   logic                    pop;
   logic                    empty;
   logic                    full;
   logic [NB-1:0]           wea;
   logic [DATA_WIDTH-1:0]   doutb;
   logic [READ_LATENCY-1:0] issue_sr;
   logic [DATA_WIDTH-1:0]   fifo [RSP_FIFO_DEPTH];
   logic [PW-1:0]           wptr;
   logic [PW-1:0]           rptr;
   logic [OW-1:0]           count;
   logic [OW-1:0]           outstanding;

   // A read to the word being written this cycle waits one cycle for the merge
   assign collide      = wr_en && (|wr_be) && (wr_addr == rd_req_addr);
   assign rd_req_ready = rstn && (outstanding < DEPTH_C) && !collide;
   assign accept       = rd_req_valid && rd_req_ready;
   assign wea          = wr_en ? wr_be : '0;
   assign push         = issue_sr[READ_LATENCY-1];
   assign empty        = (count == '0);
   assign full         = (count == DEPTH_C);
   assign rd_rsp_valid = rstn && !empty;
   assign pop          = rd_rsp_valid && rd_rsp_ready;
   assign rd_rsp_data  = rd_rsp_valid ? fifo[rptr] : '0;
   assign rd_outstanding = rstn ? outstanding : '0;

`ifdef XPMWRAP_USE_XPM
   xpm_memory_sdpram #(
      .ADDR_WIDTH_A       (ADDR_WIDTH),
      .ADDR_WIDTH_B       (ADDR_WIDTH),
      .BYTE_WRITE_WIDTH_A (BYTE_WIDTH),
      .CLOCKING_MODE      ("common_clock"),
      .MEMORY_PRIMITIVE   ("block"),
      .MEMORY_SIZE        (DATA_WIDTH * (2 ** ADDR_WIDTH)),
      .READ_DATA_WIDTH_B  (DATA_WIDTH),
      .READ_LATENCY_B     (READ_LATENCY),
      .READ_RESET_VALUE_B ("0"),
      .WRITE_DATA_WIDTH_A (DATA_WIDTH),
      .WRITE_MODE_B       ("no_change")
   ) u_ram (
      .clka           (clk),
      .ena            (wr_en),
      .wea            (wea),
      .addra          (wr_addr),
      .dina           (wr_data),
      .injectsbiterra (1'b0),
      .injectdbiterra (1'b0),
      .clkb           (clk),
      .rstb           (~rstn),
      .enb            (accept),
      .regceb         (1'b1),
      .addrb          (rd_req_addr),
      .doutb          (doutb),
      .sbiterrb       (),
      .dbiterrb       (),
      .sleep          (1'b0)
   );
`else
   logic [DATA_WIDTH-1:0] mem  [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] pipe [READ_LATENCY];

   // Byte-lane write port; contents survive reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (wea[i]) begin
            mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
               wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // Read port with a fixed READ_LATENCY register pipeline
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
      end else begin
         if (accept) pipe[0] <= mem[rd_req_addr];
         for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign doutb = pipe[READ_LATENCY-1];
`endif

   // Marks which RAM output cycles carry an accepted read
   always_ff @(posedge clk) begin
      if (!rstn) begin
         issue_sr <= '0;
      end else begin
         issue_sr[0] <= accept;
         for (int i = 1; i < READ_LATENCY; i++) issue_sr[i] <= issue_sr[i-1];
      end
   end

   // Response FIFO storage; no bypass, head is always a registered entry
   always_ff @(posedge clk) begin
      if (push) fifo[wptr] <= doutb;
   end

   // Response FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= (wptr == LAST_P) ? '0 : wptr + 1'b1;
         if (pop)  rptr <= (rptr == LAST_P) ? '0 : rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Credits: accepted reads not yet popped, bounds FIFO occupancy
   always_ff @(posedge clk) begin
      if (!rstn) begin
         outstanding <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   a_no_overflow : assert property (
      @(posedge clk) disable iff (!rstn) !(push && full)
   );

endmodule

// File: tb/tb_xpmwrap_sdpram_stream.sv
// Self-checking bench for xpmwrap_sdpram_stream.
// Expected read data comes from a bench-side memory model via a scoreboard queue.
module tb_xpmwrap_sdpram_stream;

   localparam int RL = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rd_req_valid;
   logic        rd_req_ready;
   logic [5:0]  rd_req_addr;
   logic        rd_rsp_valid;
   logic        rd_rsp_ready;
   logic [31:0] rd_rsp_data;
   logic [2:0]  rd_outstanding;

   logic [1:0]  s_valid;
   logic [1:0]  s_req_ready;
   logic [1:0]  s_rsp_valid;
   logic        s_rsp_ready = 1'b1;
   logic [5:0]  s_addr;
   logic [31:0] s_data [2];
   logic [3:0]  s8_out;
   logic [1:0]  s1_out;

   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic [31:0] model [64];
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   xpmwrap_sdpram_stream u_dut (
      .clk(clk), .rstn(rstn),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
      .rd_req_addr(rd_req_addr), .rd_rsp_valid(rd_rsp_valid),
      .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
      .rd_outstanding(rd_outstanding)
   );

   xpmwrap_sdpram_stream #(.READ_LATENCY(8), .RSP_FIFO_DEPTH(9)) u_l8 (
      .clk(clk), .rstn(rstn),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_req_valid(s_valid[0]), .rd_req_ready(s_req_ready[0]),
      .rd_req_addr(s_addr), .rd_rsp_valid(s_rsp_valid[0]),
      .rd_rsp_ready(s_rsp_ready), .rd_rsp_data(s_data[0]),
      .rd_outstanding(s8_out)
   );

   xpmwrap_sdpram_stream #(.READ_LATENCY(1), .RSP_FIFO_DEPTH(2)) u_l1 (
      .clk(clk), .rstn(rstn),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_req_valid(s_valid[1]), .rd_req_ready(s_req_ready[1]),
      .rd_req_addr(s_addr), .rd_rsp_valid(s_rsp_valid[1]),
      .rd_rsp_ready(s_rsp_ready), .rd_rsp_data(s_data[1]),
      .rd_outstanding(s1_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      for (int i = 0; i < 4; i++) if (be[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
      step();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rd_req_valid = 1'b1;
      step();
      step();
      @(negedge clk);
      total_cnt++;
      if (rd_rsp_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", rd_rsp_valid);
      else pass_cnt++;
      total_cnt++;
      if (rd_rsp_data !== 32'h0) $display("FAIL rst_data got %h want 0", rd_rsp_data);
      else pass_cnt++;
      total_cnt++;
      if (rd_outstanding !== 3'd0) $display("FAIL rst_out got %0d want 0", rd_outstanding);
      else pass_cnt++;
      total_cnt++;
      if (rd_req_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", rd_req_ready);
      else pass_cnt++;
      step();
      rstn = 1'b1;
      rd_req_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (rd_req_ready !== 1'b1) $display("FAIL post_rst_ready got %0b want 1", rd_req_ready);
      else pass_cnt++;
      step();
   endtask

   task automatic test_byte_enable();
      logic [31:0] e;
      do_write(6'd5, 32'hDEADBEEF, 4'hF);
      do_write(6'd5, 32'h000000AA, 4'h1);
      rd_rsp_ready = 1'b1;
      rd_req_valid = 1'b1;
      rd_req_addr  = 6'd5;
      @(negedge clk);
      total_cnt++;
      if (rd_req_ready !== 1'b1) $display("FAIL be_accept got %0b want 1", rd_req_ready);
      else pass_cnt++;
      exp_q.push_back(model[5]);
      step();
      rd_req_valid = 1'b0;
      for (int k = 1; k <= RL + 1; k++) begin
         @(negedge clk);
         if (k <= RL) begin
            total_cnt++;
            if (rd_rsp_valid !== 1'b0) $display("FAIL be_early k=%0d got %0b want 0", k, rd_rsp_valid);
            else pass_cnt++;
         end else begin
            total_cnt++;
            if (rd_rsp_valid !== 1'b1) $display("FAIL be_latency got %0b want 1", rd_rsp_valid);
            else pass_cnt++;
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hX;
            total_cnt++;
            if (rd_rsp_data !== e) $display("FAIL be_data got %h want %h", rd_rsp_data, e);
            else pass_cnt++;
            total_cnt++;
            if (rd_rsp_data !== 32'hDEADBEAA) $display("FAIL be_merge got %h want deadbeaa", rd_rsp_data);
            else pass_cnt++;
         end
      end
      step();
   endtask

   task automatic test_collision();
      logic [31:0] e;
      bit got = 0;
      wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'h12345678; wr_be = 4'hF;
      model[9] = 32'h12345678;
      rd_req_valid = 1'b1;
      rd_req_addr  = 6'd9;
      @(negedge clk);
      total_cnt++;
      if (rd_req_ready !== 1'b0) $display("FAIL col_stall got %0b want 0", rd_req_ready);
      else pass_cnt++;
      step();
      wr_en = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (rd_req_ready !== 1'b1) $display("FAIL col_retry got %0b want 1", rd_req_ready);
      else pass_cnt++;
      exp_q.push_back(model[9]);
      step();
      rd_req_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rd_rsp_valid) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hX;
            total_cnt++;
            if (rd_rsp_data !== e) $display("FAIL col_data got %h want %h", rd_rsp_data, e);
            else pass_cnt++;
            got = 1;
            break;
         end
      end
      total_cnt++;
      if (!got) $display("FAIL col_timeout got none want 1 response");
      else pass_cnt++;
      step();
   endtask

   task automatic test_backpressure();
      int a = 0;
      int acc = 0;
      int got = 0;
      bit took;
      logic [31:0] e;
      for (int i = 0; i < 8; i++) do_write(6'(i), 32'(i), 4'hF);
      rd_rsp_ready = 1'b0;
      rd_req_valid = 1'b1;
      rd_req_addr  = 6'd0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         took = rd_req_ready;
         if (took) begin acc++; exp_q.push_back(model[a]); end
         step();
         if (took) begin a++; rd_req_addr = 6'(a); end
      end
      @(negedge clk);
      total_cnt++;
      if (acc !== 4) $display("FAIL bp_accepts got %0d want 4", acc);
      else pass_cnt++;
      total_cnt++;
      if (rd_outstanding !== 3'd4) $display("FAIL bp_out got %0d want 4", rd_outstanding);
      else pass_cnt++;
      total_cnt++;
      if (rd_req_ready !== 1'b0) $display("FAIL bp_ready got %0b want 0", rd_req_ready);
      else pass_cnt++;
      step();
      rd_rsp_ready = 1'b1;
      for (int c = 0; c < 60 && got < 8; c++) begin
         @(negedge clk);
         if (c == 0) begin
            total_cnt++;
            if (rd_req_ready !== 1'b0) $display("FAIL bp_hold got %0b want 0", rd_req_ready);
            else pass_cnt++;
         end
         if (c == 1) begin
            total_cnt++;
            if (rd_req_ready !== 1'b1) $display("FAIL bp_rise got %0b want 1", rd_req_ready);
            else pass_cnt++;
         end
         took = rd_req_valid && rd_req_ready;
         if (took) exp_q.push_back(model[a]);
         if (rd_rsp_valid) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hX;
            total_cnt++;
            if (rd_rsp_data !== e) $display("FAIL bp_data #%0d got %h want %h", got, rd_rsp_data, e);
            else pass_cnt++;
            got++;
         end
         step();
         if (took) begin
            a++;
            if (a == 8) rd_req_valid = 1'b0;
            else rd_req_addr = 6'(a);
         end
      end
      total_cnt++;
      if (got !== 8) $display("FAIL bp_count got %0d want 8", got);
      else pass_cnt++;
      total_cnt++;
      if (exp_q.size() !== 0) $display("FAIL bp_left got %0d want 0", exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int a = 0;
      int got = 0;
      int stalls = 0;
      int maxo = 0;
      bit took;
      logic [31:0] e;
      for (int i = 0; i < 64; i++)
         do_write(6'(i), 32'hA5000000 ^ (32'(i) * 32'h00010203), 4'hF);
      rd_rsp_ready = 1'b1;
      rd_req_valid = 1'b1;
      rd_req_addr  = 6'd0;
      for (int c = 0; c < 200 && got < 64; c++) begin
         @(negedge clk);
         if (int'(rd_outstanding) > maxo) maxo = int'(rd_outstanding);
         if (rd_req_valid && !rd_req_ready) stalls++;
         took = rd_req_valid && rd_req_ready;
         if (took) exp_q.push_back(model[a]);
         if (rd_rsp_valid) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hX;
            total_cnt++;
            if (rd_rsp_data !== e) $display("FAIL stream_data #%0d got %h want %h", got, rd_rsp_data, e);
            else pass_cnt++;
            got++;
         end
         step();
         if (took) begin
            a++;
            if (a == 64) rd_req_valid = 1'b0;
            else rd_req_addr = 6'(a);
         end
      end
      total_cnt++;
      if (got !== 64) $display("FAIL stream_count got %0d want 64", got);
      else pass_cnt++;
      total_cnt++;
      if (stalls !== 0) $display("FAIL stream_stalls got %0d want 0", stalls);
      else pass_cnt++;
      total_cnt++;
      if (maxo !== RL + 1) $display("FAIL stream_maxout got %0d want %0d", maxo, RL + 1);
      else pass_cnt++;
   endtask

   task automatic test_reset_midflight();
      int acc = 0;
      int stale = 0;
      bit got = 0;
      logic [31:0] e;
      do_write(6'd5, 32'hDEADBEAA, 4'hF);
      rd_rsp_ready = 1'b0;
      rd_req_valid = 1'b1;
      rd_req_addr  = 6'd5;
      for (int c = 0; c < 10 && acc < 3; c++) begin
         @(negedge clk);
         if (rd_req_ready) acc++;
         step();
      end
      rd_req_valid = 1'b0;
      rstn = 1'b0;
      total_cnt++;
      if (acc !== 3) $display("FAIL mid_accepts got %0d want 3", acc);
      else pass_cnt++;
      step();
      rstn = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (rd_rsp_valid !== 1'b0) $display("FAIL mid_valid got %0b want 0", rd_rsp_valid);
      else pass_cnt++;
      total_cnt++;
      if (rd_outstanding !== 3'd0) $display("FAIL mid_out got %0d want 0", rd_outstanding);
      else pass_cnt++;
      exp_q.delete();
      step();
      rd_rsp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (rd_rsp_valid) stale++;
         step();
      end
      total_cnt++;
      if (stale !== 0) $display("FAIL mid_stale got %0d want 0", stale);
      else pass_cnt++;
      rd_req_valid = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (rd_req_ready !== 1'b1) $display("FAIL mid_reread got %0b want 1", rd_req_ready);
      else pass_cnt++;
      exp_q.push_back(model[5]);
      step();
      rd_req_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rd_rsp_valid) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hX;
            total_cnt++;
            if (rd_rsp_data !== e) $display("FAIL mid_data got %h want %h", rd_rsp_data, e);
            else pass_cnt++;
            got = 1;
            break;
         end
      end
      total_cnt++;
      if (!got) $display("FAIL mid_timeout got none want 1 response");
      else pass_cnt++;
      step();
   endtask

   task automatic test_latency_sweep(input int idx, input int lat_rl);
      int lat = 0;
      logic [31:0] e;
      s_addr = 6'd9;
      s_valid[idx] = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (s_req_ready[idx] !== 1'b1) $display("FAIL sweep%0d_accept got %0b want 1", lat_rl, s_req_ready[idx]);
      else pass_cnt++;
      exp_q.push_back(model[9]);
      step();
      s_valid[idx] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (s_rsp_valid[idx]) begin
            lat = k;
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hX;
            total_cnt++;
            if (s_data[idx] !== e) $display("FAIL sweep%0d_data got %h want %h", lat_rl, s_data[idx], e);
            else pass_cnt++;
            break;
         end
      end
      total_cnt++;
      if (lat !== lat_rl + 1) $display("FAIL sweep%0d_latency got %0d want %0d", lat_rl, lat, lat_rl + 1);
      else pass_cnt++;
      step();
   endtask

   initial begin
      rstn = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      rd_req_valid = 1'b0; rd_req_addr = '0; rd_rsp_ready = 1'b0;
      s_valid = '0; s_addr = '0;
      for (int i = 0; i < 64; i++) model[i] = '0;
      test_reset();
      test_byte_enable();
      test_collision();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      test_latency_sweep(0, 8);
      test_latency_sweep(1, 1);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
